// File: rtl/id_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : id_scan_arbiter
// Brief    : Shares one identifier recognizer between two char-stream
//            requesters, granting it token-by-token in round-robin order.
// Revision : 1.0
// ============================================================================
module id_scan_arbiter #(
    parameter logic [7:0] DELIM   = 8'h2F,
    parameter int         MAX_LEN = 16,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       req_char0,
    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [7:0]       req_char1,
    input  logic             req_valid1,
    output logic             req_ready1,
    output logic [7:0]       fsm_char,
    input  logic             fsm_out,
    output logic [1:0]       grant,
    output logic             tok_done,
    output logic             tok_owner,
    output logic             tok_match,
    output logic             tok_ovf,
    output logic [CNT_W-1:0] match_cnt0,
    output logic [CNT_W-1:0] match_cnt1
);

    localparam int                CHAR_W    = $clog2(MAX_LEN + 1);
    localparam logic [CHAR_W-1:0] c_max_len = CHAR_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]  c_cnt_max = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CLOSE  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_grant, w_grant_nxt;
    logic [7:0]        r_fsm_char, w_fsm_char_nxt;
    logic [CHAR_W-1:0] r_char_cnt, w_char_cnt_nxt;
    logic              r_ovf_pend, w_ovf_nxt;
    logic              r_last_owner, w_last_owner_nxt;
    logic              r_tok_done, w_tok_done_nxt;
    logic              r_tok_owner, w_tok_owner_nxt;
    logic              r_tok_match, w_tok_match_nxt;
    logic              r_tok_ovf, w_tok_ovf_nxt;
    logic [CNT_W-1:0]  r_match_cnt0, r_match_cnt1;
    logic              w_inc0, w_inc1;

    // Owner index is only meaningful while a grant is held (STREAM/CLOSE).
    logic       w_owner;
    logic       w_sel_valid;
    logic [7:0] w_sel_char;

    assign w_owner     = r_grant[1];
    assign w_sel_valid = w_owner ? req_valid1 : req_valid0;
    assign w_sel_char  = w_owner ? req_char1  : req_char0;

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_fsm_char_nxt   = r_fsm_char;
        w_char_cnt_nxt   = r_char_cnt;
        w_ovf_nxt        = r_ovf_pend;
        w_last_owner_nxt = r_last_owner;
        w_tok_done_nxt   = 1'b0;
        w_tok_owner_nxt  = r_tok_owner;
        w_tok_match_nxt  = r_tok_match;
        w_tok_ovf_nxt    = r_tok_ovf;
        w_inc0           = 1'b0;
        w_inc1           = 1'b0;
        req_ready0       = 1'b0;
        req_ready1       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_fsm_char_nxt = DELIM;
                if (req_valid0 || req_valid1) begin
                    if (req_valid0 && req_valid1)
                        w_grant_nxt = r_last_owner ? 2'b01 : 2'b10;
                    else
                        w_grant_nxt = req_valid0 ? 2'b01 : 2'b10;
                    w_char_cnt_nxt = '0;
                    w_state_nxt    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (r_char_cnt == c_max_len) begin
                    // Token too long: close it; the remaining chars form a new token.
                    w_fsm_char_nxt = DELIM;
                    w_ovf_nxt      = 1'b1;
                    w_state_nxt    = S_CLOSE;
                end else begin
                    req_ready0 = ~w_owner;
                    req_ready1 = w_owner;
                    if (w_sel_valid) begin
                        w_fsm_char_nxt = w_sel_char;
                        if (w_sel_char == DELIM)
                            w_state_nxt = S_CLOSE;
                        else
                            w_char_cnt_nxt = r_char_cnt + 1'b1;
                    end
                end
            end
            S_CLOSE: begin
                // fsm_out now reflects the last token char; DELIM resets the recognizer.
                w_fsm_char_nxt   = DELIM;
                w_tok_done_nxt   = 1'b1;
                w_tok_owner_nxt  = w_owner;
                w_tok_ovf_nxt    = r_ovf_pend;
                w_tok_match_nxt  = fsm_out & ~r_ovf_pend & (r_char_cnt != '0);
                w_inc0           = w_tok_match_nxt & ~w_owner;
                w_inc1           = w_tok_match_nxt & w_owner;
                w_last_owner_nxt = w_owner;
                w_grant_nxt      = 2'b00;
                w_ovf_nxt        = 1'b0;
                w_state_nxt      = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'b00;
            r_fsm_char   <= DELIM;
            r_char_cnt   <= '0;
            r_ovf_pend   <= 1'b0;
            r_last_owner <= 1'b1;
            r_tok_done   <= 1'b0;
            r_tok_owner  <= 1'b0;
            r_tok_match  <= 1'b0;
            r_tok_ovf    <= 1'b0;
            r_match_cnt0 <= '0;
            r_match_cnt1 <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_fsm_char   <= w_fsm_char_nxt;
            r_char_cnt   <= w_char_cnt_nxt;
            r_ovf_pend   <= w_ovf_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_tok_done   <= w_tok_done_nxt;
            r_tok_owner  <= w_tok_owner_nxt;
            r_tok_match  <= w_tok_match_nxt;
            r_tok_ovf    <= w_tok_ovf_nxt;
            if (w_inc0 && (r_match_cnt0 != c_cnt_max))
                r_match_cnt0 <= r_match_cnt0 + 1'b1;
            if (w_inc1 && (r_match_cnt1 != c_cnt_max))
                r_match_cnt1 <= r_match_cnt1 + 1'b1;
        end
    end

    assign fsm_char   = r_fsm_char;
    assign grant      = r_grant;
    assign tok_done   = r_tok_done;
    assign tok_owner  = r_tok_owner;
    assign tok_match  = r_tok_match;
    assign tok_ovf    = r_tok_ovf;
    assign match_cnt0 = r_match_cnt0;
    assign match_cnt1 = r_match_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_id_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_scan_arbiter
// Brief    : Scoreboard bench for id_scan_arbiter with a token-level model.
// Revision : 1.0
// ============================================================================
module tb_id_scan_arbiter;

    localparam logic [7:0] DELIM   = 8'h2F;
    localparam int         MAX_LEN = 16;
    localparam int         CNT_W   = 8;

    typedef struct {
        bit match;
        bit ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             vld [2];
    logic [7:0]       chr [2];
    logic             rdy0, rdy1;
    logic [7:0]       fsm_char;
    logic             fsm_out;
    logic [1:0]       grant;
    logic             tok_done, tok_owner, tok_match, tok_ovf;
    logic [CNT_W-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    int gap_pct = 0;

    logic [7:0] sq  [2][$];   // chars still to be offered per requester
    logic [7:0] cur [2][$];   // model: chars of the currently open token
    exp_t       eq  [2][$];   // expected token results per requester

    always #5 clk = ~clk;

    id_scan_arbiter #(.DELIM(DELIM), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_char0(chr[0]), .req_valid0(vld[0]), .req_ready0(rdy0),
        .req_char1(chr[1]), .req_valid1(vld[1]), .req_ready1(rdy1),
        .fsm_char(fsm_char), .fsm_out(fsm_out), .grant(grant),
        .tok_done(tok_done), .tok_owner(tok_owner), .tok_match(tok_match),
        .tok_ovf(tok_ovf), .match_cnt0(cnt0), .match_cnt1(cnt1)
    );

    function automatic bit is_alpha(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A) || c == 8'h5F;
    endfunction

    function automatic bit is_digit(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    // Recognizer standing in for id_fsm: Moore, consumes fsm_char every cycle.
    logic [1:0] rs;
    always @(posedge clk or posedge reset) begin
        if (reset)                      rs <= 2'd0;
        else if (fsm_char == DELIM)     rs <= 2'd0;
        else if (rs == 2'd0)            rs <= is_alpha(fsm_char) ? 2'd1 : 2'd2;
        else if (rs == 2'd1)            rs <= (is_alpha(fsm_char) || is_digit(fsm_char)) ? 2'd1 : 2'd2;
    end
    assign fsm_out = (rs == 2'd1);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ident_rule(input int r);
        if (cur[r].size() == 0 || !is_alpha(cur[r][0])) return 1'b0;
        foreach (cur[r][i])
            if (!(is_alpha(cur[r][i]) || is_digit(cur[r][i]))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic finalize(input int r, input bit ovf);
        exp_t e;
        e.ovf   = ovf;
        e.match = !ovf && ident_rule(r);
        eq[r].push_back(e);
        cur[r].delete();
    endtask

    // Token model: a token ends at DELIM or as soon as it holds MAX_LEN chars.
    task automatic push_char(input int r, input logic [7:0] c);
        sq[r].push_back(c);
        if (c == DELIM) finalize(r, 1'b0);
        else begin
            cur[r].push_back(c);
            if (cur[r].size() == MAX_LEN) finalize(r, 1'b1);
        end
    endtask

    task automatic push_str(input int r, input string s);
        for (int i = 0; i < s.len(); i++) push_char(r, s[i]);
    endtask

    task automatic rand_tokens(input int r, input int n);
        string cs = "abzAZ_0189";
        int len, kind;
        for (int t = 0; t < n; t++) begin
            kind = $urandom_range(0, 9);
            len  = (kind == 0) ? 0 : (kind == 1) ? $urandom_range(15, 22) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) push_char(r, cs[$urandom_range(0, 9)]);
            push_char(r, DELIM);
        end
    endtask

    // Per-requester drivers: offer the queue head, pop it once transferred.
    for (genvar g = 0; g < 2; g++) begin : g_drv
        initial begin
            logic [7:0] c;
            bit         x;
            x = 1'b0;
            c = DELIM;
            vld[g] = 1'b0;
            chr[g] = DELIM;
            forever begin
                @(negedge clk);
                if (x) begin
                    chk($sformatf("fsm_char_r%0d", g), fsm_char, c);
                    void'(sq[g].pop_front());
                    x = 1'b0;
                end
                if (!reset && sq[g].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                    c      = sq[g][0];
                    chr[g] = c;
                    vld[g] = 1'b1;
                end else begin
                    vld[g] = 1'b0;
                end
                #1;
                x = vld[g] && ((g == 0) ? rdy0 : rdy1);
            end
        end
    end

    // Monitor: token results, counters, grant choice, ready exclusivity.
    initial begin
        bit         prev_done, pv0, pv1, lo;
        logic [1:0] pg, eg;
        int         cm [2];
        int         r;
        exp_t       e;
        prev_done = 0; pv0 = 0; pv1 = 0; lo = 1; pg = 2'b00; cm[0] = 0; cm[1] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_done = 0; pv0 = 0; pv1 = 0; lo = 1; pg = 2'b00; cm[0] = 0; cm[1] = 0;
                continue;
            end
            if (tok_done) begin
                chk("tok_done_back_to_back", prev_done, 0);
                r = int'(tok_owner);
                if (eq[r].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_token: owner %0d got a result, none expected", r);
                end else begin
                    e = eq[r].pop_front();
                    chk($sformatf("tok_match_r%0d", r), tok_match, e.match);
                    chk($sformatf("tok_ovf_r%0d", r), tok_ovf, e.ovf);
                    if (e.match && cm[r] < 255) cm[r]++;
                end
                chk("match_cnt0", cnt0, cm[0]);
                chk("match_cnt1", cnt1, cm[1]);
                lo = tok_owner;
            end
            prev_done = tok_done;
            if (pg == 2'b00 && grant != 2'b00) begin
                eg = (pv0 && pv1) ? (lo ? 2'b01 : 2'b10) : pv0 ? 2'b01 : pv1 ? 2'b10 : 2'b00;
                chk("grant_choice", grant, eg);
            end
            if (grant != 2'b00)
                chk("ready_non_owner", grant[0] ? rdy1 : rdy0, 0);
            pg  = grant;
            pv0 = vld[0];
            pv1 = vld[1];
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sq[0].size() != 0 || sq[1].size() != 0 || eq[0].size() != 0 ||
                eq[1].size() != 0 || grant != 2'b00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d cycles used, limit %0d", n, budget);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_fsm_char", fsm_char, DELIM);
        chk("rst_ready0", rdy0, 0);
        chk("rst_ready1", rdy1, 0);
        chk("rst_tok_done", tok_done, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        #2 reset = 1'b0;

        gap_pct = 0;
        push_str(0, "abcd1234/");
        wait_drain(200);
        chk("single_cnt0", cnt0, 1);

        for (int i = 0; i < 3; i++) begin
            push_str(0, "ab/");
            push_str(1, "1a/");
        end
        wait_drain(300);
        chk("rr_cnt0", cnt0, 4);
        chk("rr_cnt1", cnt1, 0);

        push_str(0, "abcdefghijklmnopqrst/");
        wait_drain(300);
        chk("ovf_cnt0", cnt0, 5);

        push_str(1, "/");
        wait_drain(100);
        chk("empty_cnt1", cnt1, 0);

        gap_pct = 30;
        rand_tokens(0, 40);
        rand_tokens(1, 40);
        wait_drain(8000);

        gap_pct = 0;
        push_str(0, "ab");
        for (int n = 0; n < 100 && sq[0].size() != 0; n++) @(negedge clk);
        chk("mid_token_queue_left", sq[0].size(), 0);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_fsm_char", fsm_char, DELIM);
        chk("async_rst_ready0", rdy0, 0);
        chk("async_rst_tok_done", tok_done, 0);
        chk("async_rst_cnt0", cnt0, 0);
        chk("async_rst_cnt1", cnt1, 0);
        cur[0].delete();
        cur[1].delete();
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;
        push_str(0, "ab/");
        push_str(1, "_z/");
        wait_drain(200);
        chk("post_rst_cnt0", cnt0, 1);
        chk("post_rst_cnt1", cnt1, 1);

        for (int i = 0; i < 256; i++) push_str(0, "a/");
        wait_drain(4000);
        chk("sat_cnt0", cnt0, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_scan_arbiter.md
Name: id_scan_arbiter

Overview:
- Shares one identifier recognizer (id_fsm: 8-bit char in, 1-bit out, same clk) between two character-stream requesters.
- Grants the recognizer for a whole token. A token is the run of chars up to a delimiter, default "/".
- Drives the recognizer's char input and closes each token.
- Samples the match result, reports it per requester, and switches owner round-robin at token boundaries.

Parameters:
- DELIM, 8'h2F ("/"): token delimiter; also the char driven to the recognizer when idle or closing.
- MAX_LEN, 16: maximum non-delimiter chars per token before a forced close.
- CNT_W, 8: width of the per-requester match counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_char0  in  8  requester 0 char.
- req_valid0  in  1  requester 0 char valid.
- req_ready0  out  1  requester 0 char accepted (transfer = valid & ready).
- req_char1  in  8  requester 1 char.
- req_valid1  in  1  requester 1 char valid.
- req_ready1  out  1  requester 1 char accepted.
- fsm_char  out  8  registered char to the recognizer's char input.
- fsm_out  in  1  recognizer match output (Moore; reflects all chars consumed so far).
- grant  out  2  one-hot current owner; 2'b00 when idle.
- tok_done  out  1  one-cycle pulse when a token result is reported.
- tok_owner  out  1  owner of the reported token; valid while tok_done is high.
- tok_match  out  1  token recognized as identifier; valid while tok_done is high.
- tok_ovf  out  1  token was force-closed by MAX_LEN; valid while tok_done is high.
- match_cnt0  out  CNT_W  saturating count of matched tokens, requester 0.
- match_cnt1  out  CNT_W  saturating count of matched tokens, requester 1.

Behaviour:
- Reset values: state IDLE, grant 0, fsm_char DELIM, req_ready0/1 0, tok_* 0, match_cnt0/1 0, char_cnt 0, last_owner 1 (so requester 0 wins first).
- Reset mid-token discards the token silently.
- States: IDLE, STREAM, CLOSE.
- IDLE:
  - ready 0; fsm_char held at DELIM.
  - If exactly one req_valid is high, grant that requester.
  - If both are high, grant the one != last_owner.
  - Next edge: grant register set, state becomes STREAM, char_cnt cleared.
  - A requester therefore waits at least one cycle after asserting valid.
- STREAM:
  - Owner's ready = 1 while char_cnt < MAX_LEN; the non-owner's ready is always 0.
  - On transfer of a non-DELIM char: fsm_char <= char, char_cnt += 1.
  - On transfer of DELIM: fsm_char <= DELIM, state becomes CLOSE.
  - If char_cnt == MAX_LEN: ready 0, fsm_char <= DELIM, ovf_pend set, state becomes CLOSE. Later chars start a new token.
  - No transfer: fsm_char holds its value.
- CLOSE (exactly 1 cycle):
  - ready 0; fsm_char = DELIM.
  - During this cycle fsm_out reflects the recognizer state after the last token char.
  - At the edge ending CLOSE, the following are registered (visible in the next cycle):
    - tok_done = 1 and tok_owner = owner.
    - tok_ovf = ovf_pend.
    - tok_match = fsm_out & ~ovf_pend & (char_cnt != 0).
  - If tok_match is set, the owner's match_cnt increments, saturating at all-ones.
  - last_owner <= owner; grant <= 0; ovf_pend cleared; state becomes IDLE.
- Empty token (DELIM with char_cnt == 0): still passes through CLOSE. tok_done pulses with tok_match = 0, and no counter changes.
- Token turnaround: DELIM transfer → CLOSE → IDLE → next grant. At most one transfer per 3 cycles at token boundaries; one char per cycle inside a token.
- Back-to-back requests from the same single requester are re-granted after IDLE with no penalty beyond the IDLE cycle.
- tok_done is never high in two consecutive cycles.

Test Plan:
1. Bench instantiates id_fsm as the recognizer. Only requester 0 streams "abcd1234/" one char per cycle → ready0 high for 9 transfers. Next:
   - tok_done pulses once: owner 0, match 1, ovf 0; match_cnt0 = 1.
   - fsm_char sequence: 'a'..'4', then DELIM.
2. Both requesters hold valid from reset: requester 0 sends "ab/", requester 1 sends "1a/" → grant order 01,10,01,… Results: owner 0 match 1; owner 1 match 0; match_cnt0 = 1, match_cnt1 = 0; req_ready1 stays 0 throughout requester 0's token.
3. Requester 0 sends 20 letters with no DELIM (MAX_LEN 16) → after 16 transfers ready0 drops. Results:
   - First token: ovf 1, match 0, match_cnt0 unchanged.
   - Remaining 4 chars plus "/" form a second token: match 1.
4. Requester 1 sends "/" alone → tok_done with owner 1, match 0, ovf 0; counters unchanged; then IDLE.
5. Assert reset asynchronously mid-token after "ab" → outputs immediately return to reset values (grant 0, fsm_char DELIM, counters 0), with no tok_done. The next token is granted to requester 0 first.
6. Feed 256 matched tokens from requester 0 with CNT_W = 8 → match_cnt0 saturates at 255.
